requant_pipeline: RTL and testbench
===================================

Name: requant_pipeline

Overview:
- Pipelined requantization stage between the MAC-array accumulator drain and the saturating narrowing stage.
- Per accumulator beat, it applies: bias add, fixed-point scale multiply, rounding right shift, optional ReLU, then clamp to ACC_WIDTH.
- The result feeds the narrowing stage, which reduces it to DATA_WIDTH.
- Valid/ready on both sides; 3-stage pipeline with per-stage stall.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (8), element width of the downstream narrowed output; carried for package consistency only.
- ACC_WIDTH, `ACC_WIDTH (32), signed accumulator width on input and output.
- SCALE_WIDTH, 16, unsigned scale multiplier width.
- SHIFT_WIDTH, 6, width of the right-shift amount.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat when in_valid and in_ready are both high.
- in_acc  input  ACC_WIDTH  signed accumulator value.
- cfg_bias  input  ACC_WIDTH  signed bias; sampled with the beat.
- cfg_scale  input  SCALE_WIDTH  unsigned multiplier; sampled with the beat.
- cfg_shift  input  SHIFT_WIDTH  right-shift amount, 0..2^SHIFT_WIDTH-1; sampled with the beat.
- cfg_relu  input  1  1 = clamp negatives to 0; sampled with the beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  ACC_WIDTH  signed requantized value, clamped to the ACC_WIDTH range.

Behaviour:
- Reset (asynchronous, active-low):
  - All stage valid bits clear; out_valid=0, out_data=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards every in-flight beat.
- Stage 1 (S1), on accept:
  - Register sum = in_acc + cfg_bias at ACC_WIDTH+1 bits, with no wrap.
  - Register cfg_scale, cfg_shift and cfg_relu alongside the sum.
  - Config changes therefore never affect beats already accepted.
- Stage 2 (S2):
  - prod = sum * signed({1'b0, scale}), width ACC_WIDTH+SCALE_WIDTH+2, exact.
- Stage 3 (S3):
  - If shift==0: r = prod.
  - Otherwise: r = (prod + (1 << (shift-1))) >>> shift, computed at prod width + 1. This is round-half-toward-+inf.
  - Shifts at or beyond the prod width yield 0 or -1 via the arithmetic shift; no X.
  - If relu and r<0, then r=0.
  - Clamp r to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], then register into out_data.
- Latency: 3 cycles from accept to out_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Flow control (bubble-collapsing):
  - advance3 = !v3 | out_ready
  - advance2 = !v2 | (v3 ? out_ready : 1); equivalently, S2 moves when S3 is empty or emptying.
  - advance1 likewise.
  - in_ready = !v1 | advance1.
  - A stalled stage holds both its data and its valid.
  - in_ready has no combinational path from in_valid. It may depend combinationally on out_ready.
- Capacity: 3 beats in flight. With out_ready held low, exactly 3 beats are accepted, then in_ready=0.
- Order is strictly preserved; no beat is dropped or duplicated.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept at input and drain at output in the same cycle is legal and sustains 1/cycle.

Decomposition:
- Shared package (npu_pkg) holds:
  - the ACC_WIDTH/DATA_WIDTH-derived localparams: SUM_W = ACC_WIDTH+1, PROD_W = ACC_WIDTH+SCALE_WIDTH+2;
  - acc_min/acc_max constants;
  - the typedef struct requant_cfg_t {bias, scale, shift, relu}, which travels down the pipe with the data.
- One sub-module, round_shift_clamp: purely combinational S3 datapath (rounding shift, ReLU, clamp). It is unit-testable in isolation.
- Pipeline registers and handshake stay in the top module.

Test Plan:
- Basic: acc=1000, bias=24, scale=1, shift=0, relu=0, out_ready=1 -> out_data=1024 exactly 3 cycles after accept.
- Rounding:
  - acc=5, bias=0, scale=1, shift=1 -> 3.
  - acc=-5 -> -2.
  - acc=6, scale=3, shift=2 -> (18+2)>>2 = 5.
- Saturation and ReLU:
  - acc=0x7FFFFFFF, bias=1, scale=1, shift=0 -> 0x7FFFFFFF.
  - acc=-2^31, bias=-1 -> -2^31.
  - acc=-100, relu=1 -> 0.
- Backpressure: stream 10 beats (acc=0..9, bias=0, scale=2, shift=0) with out_ready=0 for 6 cycles.
  - Required: in_ready=0 after 3 accepts; out_data held at 0.
  - After release: outputs 0,2,...,18 in order, with no gaps while in_valid stays high.
- Config isolation: change cfg_scale 1->4 on the cycle after a beat acc=7 is accepted -> that beat emits 7; the next beat acc=7 emits 28.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately (asynchronous). After release, no stale beat appears and the first new beat has 3-cycle latency.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared widths, clamp limits and the per-beat requantization config for the
// NPU post-accumulator datapath.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package npu_pkg;
  localparam int DATA_WIDTH  = `DATA_WIDTH;
  localparam int ACC_WIDTH   = `ACC_WIDTH;
  localparam int SCALE_WIDTH = 16;
  localparam int SHIFT_WIDTH = 6;
  localparam int SUM_W       = ACC_WIDTH + 1;
  localparam int PROD_W      = ACC_WIDTH + SCALE_WIDTH + 2;

  localparam logic [ACC_WIDTH-1:0] acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};

  // Fields still needed after the bias add; this part rides down the pipe.
  typedef struct packed {
    logic [SCALE_WIDTH-1:0] scale;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu;
  } requant_post_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] bias;
    requant_post_t        post;
  } requant_cfg_t;
endpackage

// File: rtl/requant_pipeline_if.sv
// Upstream/downstream stream bus of the requantization stage.
interface requant_pipeline_if;
  import npu_pkg::*;

  // Both sides: a beat transfers on a rising edge where valid && ready; the
  // sender holds valid and payload stable until that edge.
  logic                   in_valid;
  logic                   in_ready;
  logic [ACC_WIDTH-1:0]   in_acc;
  logic [ACC_WIDTH-1:0]   cfg_bias;
  logic [SCALE_WIDTH-1:0] cfg_scale;
  logic [SHIFT_WIDTH-1:0] cfg_shift;
  logic                   cfg_relu;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_acc, cfg_bias, cfg_scale, cfg_shift, cfg_relu, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_acc, cfg_bias, cfg_scale, cfg_shift, cfg_relu, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/requant_pipeline_round_shift_clamp.sv
// Combinational tail of the requantizer: round-half-up right shift, optional
// ReLU and saturation to the accumulator range.
module round_shift_clamp
  import npu_pkg::*;
(
  input  logic signed [PROD_W-1:0]    prod,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                        relu,
  output logic signed [ACC_WIDTH-1:0] result
);

  localparam logic signed [PROD_W:0] max_ext = {{(PROD_W-ACC_WIDTH+1){1'b0}}, acc_max};
  localparam logic signed [PROD_W:0] min_ext = {{(PROD_W-ACC_WIDTH+1){1'b1}}, acc_min};

  logic signed [PROD_W:0] ext;
  logic signed [PROD_W:0] rnd;
  logic signed [PROD_W:0] shifted;

  // One guard bit keeps the rounding add from wrapping; oversized shifts
  // simply drain to the sign (0 or -1).
  always_comb begin
    ext     = {prod[PROD_W-1], prod};
    rnd     = '0;
    shifted = ext;
    if (shift != '0) begin
      rnd     = (PROD_W+1)'(1) << (shift - SHIFT_WIDTH'(1));
      shifted = (ext + rnd) >>> shift;
    end
    if (relu && shifted[PROD_W]) shifted = '0;
    if (shifted > max_ext)      result = acc_max;
    else if (shifted < min_ext) result = acc_min;
    else                        result = shifted[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/requant_pipeline.sv
// Three-stage requantizer: S1 bias add, S2 scale multiply, S3 round/ReLU/clamp,
// with bubble-collapsing valid/ready flow control.
module requant_pipeline
  import npu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  requant_pipeline_if.slave  bus
);

  logic v1, v2, v3;
  logic adv1, adv2, adv3;

  requant_cfg_t              cfg_in;
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   s1_sum;
  requant_post_t             s1_cfg;
  logic signed [SCALE_WIDTH:0] scale_s;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [PROD_W-1:0]  s2_prod;
  logic [SHIFT_WIDTH-1:0]    s2_shift;
  logic                      s2_relu;
  logic signed [ACC_WIDTH-1:0] rsc_result;
  logic signed [ACC_WIDTH-1:0] s3_data;

  // A stage may load whenever the stage below it is empty or emptying.
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.out_data  = s3_data;

  assign cfg_in = '{bias: bus.cfg_bias,
                    post: '{scale: bus.cfg_scale, shift: bus.cfg_shift, relu: bus.cfg_relu}};
  assign sum_c  = {bus.in_acc[ACC_WIDTH-1], bus.in_acc} + {cfg_in.bias[ACC_WIDTH-1], cfg_in.bias};

  assign scale_s = {1'b0, s1_cfg.scale};
  assign prod_c  = PROD_W'(s1_sum) * PROD_W'(scale_s);

  round_shift_clamp u_rsc (
    .prod   (s2_prod),
    .shift  (s2_shift),
    .relu   (s2_relu),
    .result (rsc_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_sum <= '0;
      s1_cfg <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sum <= sum_c;
        s1_cfg <= cfg_in.post;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      s2_prod  <= '0;
      s2_shift <= '0;
      s2_relu  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2_prod  <= prod_c;
        s2_shift <= s1_cfg.shift;
        s2_relu  <= s1_cfg.relu;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      s3_data <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) s3_data <= rsc_result;
    end
  end

endmodule

// File: tb/tb_requant_pipeline.sv
// Self-checking bench for requant_pipeline: vector table, hand-written
// backpressure/config/reset sequences and a randomized stream.
module tb_requant_pipeline;
  import npu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  requant_pipeline_if bus();
  requant_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] bias;
    logic [SCALE_WIDTH-1:0]      scale;
    logic [SHIFT_WIDTH-1:0]      shift;
    logic                        relu;
    logic [ACC_WIDTH-1:0]        exp;
  } vec_t;

  vec_t vecs[15];
  logic [ACC_WIDTH-1:0] exp_q[$];
  int cyc_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int prev_out_cyc = -1;
  int gap_err = 0;
  logic [ACC_WIDTH-1:0] cur_exp = '0;
  logic lat_chk = 1'b0;
  logic gap_chk = 1'b0;
  logic held = 1'b0;
  logic [ACC_WIDTH-1:0] held_data = '0;
  logic bp_done = 1'b0;
  logic rnd_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ACC_WIDTH-1:0] model(input logic signed [31:0] acc,
      input logic signed [31:0] bias, input logic [15:0] scale,
      input logic [5:0] shift, input logic relu);
    longint s, p, r;
    s = longint'(acc) + longint'(bias);
    p = s * longint'(scale);
    if (shift == 0)       r = p;
    else if (shift <= 50) r = (p + (longint'(1) << (shift - 1))) >>> shift;
    else                  r = (p < 0) ? -1 : 0;
    if (relu && r < 0) r = 0;
    if (r > 64'sd2147483647)  r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[31:0];
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: push on accept, pop and compare on output transfer.
  always @(negedge clk) begin
    logic [ACC_WIDTH-1:0] e;
    int c;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(held_data));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(cur_exp);
        cyc_q.push_back(cyc);
        acc_cnt++;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e));
          if (lat_chk) check("latency", 64'(cyc - c), 64'd3);
        end
        if (gap_chk) begin
          if (prev_out_cyc >= 0 && cyc != prev_out_cyc + 1) gap_err++;
          prev_out_cyc = cyc;
        end
      end
      held = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
    end
  end

  task automatic send(input logic signed [31:0] acc, input logic signed [31:0] bias,
      input logic [15:0] scale, input logic [5:0] shift, input logic relu,
      input logic [31:0] exp);
    int budget;
    logic took;
    budget = 0;
    bus.in_acc = acc;
    bus.cfg_bias = bias;
    bus.cfg_scale = scale;
    bus.cfg_shift = shift;
    bus.cfg_relu = relu;
    cur_exp = exp;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!took && budget < 100);
    if (!took) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %0b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_acc = '0;
    bus.cfg_bias = '0;
    bus.cfg_scale = '0;
    bus.cfg_shift = '0;
    bus.cfg_relu = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    vecs[0]  = '{acc: 1000, bias: 24, scale: 1, shift: 0, relu: 0, exp: 32'd1024};
    vecs[1]  = '{acc: 5, bias: 0, scale: 1, shift: 1, relu: 0, exp: 32'd3};
    vecs[2]  = '{acc: -5, bias: 0, scale: 1, shift: 1, relu: 0, exp: 32'hFFFF_FFFE};
    vecs[3]  = '{acc: 6, bias: 0, scale: 3, shift: 2, relu: 0, exp: 32'd5};
    vecs[4]  = '{acc: 32'h7FFF_FFFF, bias: 1, scale: 1, shift: 0, relu: 0, exp: 32'h7FFF_FFFF};
    vecs[5]  = '{acc: 32'h8000_0000, bias: -1, scale: 1, shift: 0, relu: 0, exp: 32'h8000_0000};
    vecs[6]  = '{acc: -100, bias: 0, scale: 1, shift: 0, relu: 1, exp: 32'd0};
    vecs[7]  = '{acc: 100, bias: 0, scale: 1, shift: 0, relu: 1, exp: 32'd100};
    vecs[8]  = '{acc: -7, bias: 0, scale: 1, shift: 2, relu: 0, exp: 32'hFFFF_FFFE};
    vecs[9]  = '{acc: -6, bias: 0, scale: 1, shift: 2, relu: 0, exp: 32'hFFFF_FFFF};
    vecs[10] = '{acc: 32'h4000_0000, bias: 0, scale: 4, shift: 0, relu: 0, exp: 32'h7FFF_FFFF};
    vecs[11] = '{acc: -1000, bias: 0, scale: 65535, shift: 63, relu: 0, exp: 32'hFFFF_FFFF};
    vecs[12] = '{acc: 1000, bias: 0, scale: 65535, shift: 63, relu: 0, exp: 32'd0};
    vecs[13] = '{acc: 32'h7FFF_FFFF, bias: 32'h7FFF_FFFF, scale: 65535, shift: 20, relu: 0, exp: 32'd268431360};
    vecs[14] = '{acc: 32'h8000_0000, bias: 32'h8000_0000, scale: 65535, shift: 0, relu: 0, exp: 32'h8000_0000};

    lat_chk = 1'b1;
    for (int i = 0; i < 15; i++)
      send(vecs[i].acc, vecs[i].bias, vecs[i].scale, vecs[i].shift, vecs[i].relu, vecs[i].exp);
    wait_drain();

    // Config change right after acceptance must not touch the in-flight beat.
    send(7, 0, 1, 0, 0, 32'd7);
    bus.cfg_scale = 16'd4;
    @(posedge clk);
    #1;
    send(7, 0, 4, 0, 0, 32'd28);
    wait_drain();

    // Backpressure: pipe fills to three, then releases with no gaps.
    lat_chk = 1'b0;
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i, 0, 2, 0, 0, 32'(2 * i));
        bp_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_accepts", 64'(acc_cnt), 64'd3);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    check("bp_out_data", 64'(bus.out_data), 64'd0);
    gap_chk = 1'b1;
    prev_out_cyc = -1;
    gap_err = 0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < 200 && !bp_done; b++) begin
      @(posedge clk);
      #1;
    end
    check("bp_done", 64'(bp_done), 64'd1);
    wait_drain();
    check("bp_gaps", 64'(gap_err), 64'd0);
    gap_chk = 1'b0;

    // Reset with three beats in flight.
    bus.out_ready = 1'b0;
    send(11, 0, 1, 0, 0, 32'd11);
    send(12, 0, 1, 0, 0, 32'd12);
    send(13, 0, 1, 0, 0, 32'd13);
    check("mid_full_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(bus.out_data), 64'd0);
    exp_q.delete();
    cyc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    out_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    check("no_stale", 64'(out_cnt), 64'd0);
    lat_chk = 1'b1;
    send(42, 0, 1, 0, 0, 32'd42);
    wait_drain();
    check("post_rst_count", 64'(out_cnt), 64'd1);

    // Randomized stream with random downstream stalls.
    lat_chk = 1'b0;
    rnd_done = 1'b0;
    fork
      while (!rnd_done) begin
        @(posedge clk);
        #1;
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      logic signed [31:0] ra, rb;
      logic [15:0] rs;
      logic [5:0] rh;
      logic rr;
      ra = $urandom;
      rb = $urandom;
      rs = 16'($urandom_range(0, 65535));
      rh = 6'($urandom_range(0, 50));
      rr = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rh, rr, model(ra, rb, rs, rh, rr));
    end
    rnd_done = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
